redirect_ctrl: RTL and testbench

- Sequences front-end redirection after a resolved control transfer.
- Accepts the taken/flush decision and target from the branch/jump decision unit, plus a trap redirect from the trap unit. Arbitrates between them, with trap winning.
- Squashes the IF/ID pipeline registers and issues the new fetch address to instruction memory with a req/ack handshake.
- After the ack, holds a fixed drain window to discard in-flight fetches before returning to normal sequential fetch.

---
 rtl/redirect_ctrl.sv | 156 +++++++++++++++
 tb/tb_redirect_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/redirect_ctrl.sv
// redirect_ctrl: sequences a front-end redirect after a resolved branch/jump
// or a trap. The accepted target is latched, issued to instruction memory
// with a req/ack handshake, and followed by a fixed drain window that keeps
// the IF/ID stage squashed while stale fetches retire.
// FLUSH_CYCLES must lie in 1..15 (the drain counter is 4 bits wide).
module redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_branch_flush,
  input  logic [31:0]      i_branch_pc,
  input  logic             i_trap,
  input  logic [31:0]      i_trap_pc,
  input  logic             i_imem_ack,
  output logic             o_imem_req,
  output logic [31:0]      o_redirect_pc,
  output logic             o_pc_redirect,
  output logic             o_flush_if,
  output logic             o_flush_id,
  output logic             o_hold_fetch,
  output logic             o_busy,
  output logic             o_misalign_err,
  output logic [CNT_W-1:0] o_redirect_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0]       DRAIN_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e            state_q;
  logic [31:0]       target_q;
  logic [3:0]        drain_q;
  logic [CNT_W-1:0]  cnt_q;

  logic in_run_s;
  logic in_issue_s;
  logic in_drain_s;
  logic br_cand_s;
  logic br_acc_s;
  logic trap_acc_s;
  logic mis_s;

  // Decode the current state and classify this cycle's redirect requests.
  // A branch only counts in RUN, when not stalled and not beaten by a trap;
  // its target alignment decides between accept and misalign reject.
  always_comb begin
    in_run_s   = (state_q == S_RUN);
    in_issue_s = (state_q == S_ISSUE);
    in_drain_s = (state_q == S_DRAIN);
    trap_acc_s = in_run_s & i_trap;
    br_cand_s  = in_run_s & i_branch_flush & ~i_stall & ~i_trap;
    if (i_branch_pc[1:0] == 2'b00) begin
      br_acc_s = br_cand_s;
      mis_s    = 1'b0;
    end else begin
      br_acc_s = 1'b0;
      mis_s    = br_cand_s;
    end
  end

  // Redirect FSM: target latch, drain countdown and saturating redirect count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      target_q <= 32'd0;
      drain_q  <= 4'd0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_RUN: begin
          if (trap_acc_s) begin
            target_q <= i_trap_pc;
            state_q  <= S_ISSUE;
          end else if (br_acc_s) begin
            target_q <= i_branch_pc;
            state_q  <= S_ISSUE;
          end else begin
            state_q  <= S_RUN;
          end
        end
        S_ISSUE: begin
          // An ack always completes the current redirect, even if a trap
          // arrives in the same cycle and immediately starts a new one.
          if (i_imem_ack) begin
            drain_q <= DRAIN_LOAD;
            if (cnt_q != CNT_MAX) begin
              cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              cnt_q <= cnt_q;
            end
          end else begin
            drain_q <= drain_q;
          end
          if (i_trap) begin
            target_q <= i_trap_pc;
            state_q  <= S_ISSUE;
          end else if (i_imem_ack) begin
            state_q  <= S_DRAIN;
          end else begin
            state_q  <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (i_trap) begin
            target_q <= i_trap_pc;
            state_q  <= S_ISSUE;
          end else if (drain_q <= 4'd1) begin
            drain_q  <= 4'd0;
            state_q  <= S_RUN;
          end else begin
            drain_q  <= drain_q - 4'd1;
            state_q  <= S_DRAIN;
          end
        end
        default: begin
          state_q <= S_RUN;
          drain_q <= 4'd0;
        end
      endcase
    end
  end

  // Output decode. Outputs are forced low while reset is asserted so a
  // redirect abandoned by reset never produces a PC load pulse.
  always_comb begin
    if (rst) begin
      o_imem_req     = 1'b0;
      o_pc_redirect  = 1'b0;
      o_flush_if     = 1'b0;
      o_flush_id     = 1'b0;
      o_hold_fetch   = 1'b0;
      o_busy         = 1'b0;
      o_misalign_err = 1'b0;
    end else begin
      o_imem_req     = in_issue_s;
      o_pc_redirect  = in_issue_s & i_imem_ack;
      o_flush_if     = in_issue_s | in_drain_s;
      o_flush_id     = in_issue_s | trap_acc_s | br_acc_s;
      o_hold_fetch   = in_issue_s;
      o_busy         = ~in_run_s;
      o_misalign_err = mis_s;
    end
  end

  assign o_redirect_pc  = target_q;
  assign o_redirect_cnt = cnt_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Bench for redirect_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a phase-based
// behavioural model (phase 0 = running, -1 = waiting for ack, k>0 = k
// drain cycles left).
module tb_redirect_ctrl;
  localparam int FC   = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_stall = 1'b0, i_branch_flush = 1'b0, i_trap = 1'b0, i_imem_ack = 1'b0;
  logic [31:0]   i_branch_pc = 32'd0, i_trap_pc = 32'd0;
  logic          o_imem_req, o_pc_redirect, o_flush_if, o_flush_id, o_hold_fetch, o_busy, o_misalign_err;
  logic [31:0]   o_redirect_pc;
  logic [CW-1:0] o_redirect_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  int          m_phase = 0;
  logic [31:0] m_tgt   = 32'd0;
  int          m_cnt   = 0;

  redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_branch_flush(i_branch_flush),
    .i_branch_pc(i_branch_pc), .i_trap(i_trap), .i_trap_pc(i_trap_pc),
    .i_imem_ack(i_imem_ack), .o_imem_req(o_imem_req), .o_redirect_pc(o_redirect_pc),
    .o_pc_redirect(o_pc_redirect), .o_flush_if(o_flush_if), .o_flush_id(o_flush_id),
    .o_hold_fetch(o_hold_fetch), .o_busy(o_busy), .o_misalign_err(o_misalign_err),
    .o_redirect_cnt(o_redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare against the model at the falling edge, then advance
  // the model at the rising edge using the inputs the DUT saw.
  task automatic step();
    bit run, iss, drn, tacc, bok, br, mis;
    @(negedge clk);
    run  = (m_phase == 0);
    iss  = (m_phase < 0);
    drn  = (m_phase > 0);
    tacc = run && i_trap;
    bok  = run && i_branch_flush && !i_stall && !i_trap;
    br   = bok && (i_branch_pc[1:0] == 2'b00);
    mis  = bok && (i_branch_pc[1:0] != 2'b00);
    if (!rst) begin
      chk("m_req",      {31'd0, o_imem_req},     {31'd0, iss});
      chk("m_pc_redir", {31'd0, o_pc_redirect},  {31'd0, iss && i_imem_ack});
      chk("m_flush_if", {31'd0, o_flush_if},     {31'd0, iss || drn});
      chk("m_flush_id", {31'd0, o_flush_id},     {31'd0, iss || tacc || br});
      chk("m_hold",     {31'd0, o_hold_fetch},   {31'd0, iss});
      chk("m_busy",     {31'd0, o_busy},         {31'd0, !run});
      chk("m_misalign", {31'd0, o_misalign_err}, {31'd0, mis});
      chk("m_cnt",      {30'd0, o_redirect_cnt}, m_cnt);
      if (iss) chk("m_rpc", o_redirect_pc, m_tgt);
    end
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_tgt = 32'd0; m_cnt = 0;
    end else if (run) begin
      if (i_trap) begin m_tgt = i_trap_pc; m_phase = -1; end
      else if (br) begin m_tgt = i_branch_pc; m_phase = -1; end
    end else if (iss) begin
      if (i_imem_ack) begin
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        m_phase = FC;
      end
      if (i_trap) begin m_tgt = i_trap_pc; m_phase = -1; end
    end else begin
      if (i_trap) begin m_tgt = i_trap_pc; m_phase = -1; end
      else m_phase = m_phase - 1;
    end
    #1;
  endtask

  task automatic idle();
    i_stall = 1'b0; i_branch_flush = 1'b0; i_trap = 1'b0; i_imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  initial begin
    int pulses;
    #1;
    do_reset();
    #1;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_req",  {31'd0, o_imem_req}, 32'd0);
    chk("rst_rpc",  o_redirect_pc, 32'd0);
    chk("rst_cnt",  {30'd0, o_redirect_cnt}, 32'd0);
    step();

    // Branch to 0x100, ack on the following cycle.
    i_branch_flush = 1'b1; i_branch_pc = 32'h100; #1;
    chk("t1_flush_id", {31'd0, o_flush_id}, 32'd1);
    step();
    i_branch_flush = 1'b0; i_imem_ack = 1'b1; #1;
    chk("t1_req", {31'd0, o_imem_req}, 32'd1);
    chk("t1_pcr", {31'd0, o_pc_redirect}, 32'd1);
    chk("t1_rpc", o_redirect_pc, 32'h100);
    step();
    i_imem_ack = 1'b0; #1;
    chk("t1_drain1", {31'd0, o_flush_if}, 32'd1);
    chk("t1_cnt", {30'd0, o_redirect_cnt}, 32'd1);
    step(); #1;
    chk("t1_drain2", {31'd0, o_flush_if}, 32'd1);
    step(); #1;
    chk("t1_run_busy", {31'd0, o_busy}, 32'd0);
    chk("t1_run_fif", {31'd0, o_flush_if}, 32'd0);
    step();

    // Same branch with the ack delayed three cycles.
    i_branch_flush = 1'b1; i_branch_pc = 32'h100; step();
    i_branch_flush = 1'b0; pulses = 0;
    for (int k = 0; k < 4; k++) begin
      i_imem_ack = (k == 3); #1;
      chk("t2_req", {31'd0, o_imem_req}, 32'd1);
      chk("t2_rpc", o_redirect_pc, 32'h100);
      pulses += int'(o_pc_redirect);
      step();
    end
    i_imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin #1; pulses += int'(o_pc_redirect); step(); end
    chk("t2_pulses", pulses, 32'd1);

    // Trap and branch together: trap wins, no misalign.
    i_trap = 1'b1; i_trap_pc = 32'h40; i_branch_flush = 1'b1; i_branch_pc = 32'h200; #1;
    chk("t3_mis", {31'd0, o_misalign_err}, 32'd0);
    step();
    idle(); #1;
    chk("t3_rpc", o_redirect_pc, 32'h40);
    i_imem_ack = 1'b1; step(); idle(); step(); step();

    // Trap during drain of a branch redirect.
    do_reset();
    i_branch_flush = 1'b1; i_branch_pc = 32'h300; step();
    idle(); i_imem_ack = 1'b1; step();
    idle(); i_trap = 1'b1; i_trap_pc = 32'h80; step();
    idle(); #1;
    chk("t4_rpc", o_redirect_pc, 32'h80);
    chk("t4_req", {31'd0, o_imem_req}, 32'd1);
    chk("t4_cnt1", {30'd0, o_redirect_cnt}, 32'd1);
    step();
    i_imem_ack = 1'b1; step(); idle(); #1;
    chk("t4_cnt2", {30'd0, o_redirect_cnt}, 32'd2);
    step(); step();

    // Misaligned branch, stalled branch, branch during ISSUE.
    i_branch_flush = 1'b1; i_branch_pc = 32'h102; #1;
    chk("t5_mis", {31'd0, o_misalign_err}, 32'd1);
    step(); idle(); #1;
    chk("t5_busy", {31'd0, o_busy}, 32'd0);
    i_branch_flush = 1'b1; i_branch_pc = 32'h500; i_stall = 1'b1; #1;
    chk("t6_fid", {31'd0, o_flush_id}, 32'd0);
    step(); idle(); #1;
    chk("t6_busy", {31'd0, o_busy}, 32'd0);
    i_branch_flush = 1'b1; i_branch_pc = 32'h600; step();
    i_branch_pc = 32'h703; #1;
    chk("t7_mis", {31'd0, o_misalign_err}, 32'd0);
    step(); #1;
    chk("t7_rpc", o_redirect_pc, 32'h600);

    // Reset while in ISSUE with ack present.
    idle(); rst = 1'b1; i_imem_ack = 1'b1; #1;
    chk("t8_pcr", {31'd0, o_pc_redirect}, 32'd0);
    step(); rst = 1'b0; idle(); #1;
    chk("t8_req", {31'd0, o_imem_req}, 32'd0);
    chk("t8_busy", {31'd0, o_busy}, 32'd0);
    chk("t8_rpc", o_redirect_pc, 32'd0);
    chk("t8_cnt", {30'd0, o_redirect_cnt}, 32'd0);

    // Four redirects saturate a 2-bit counter at 3.
    for (int i = 0; i < 4; i++) begin
      i_branch_flush = 1'b1; i_branch_pc = 32'h400 + 32'(16 * i); step();
      idle(); i_imem_ack = 1'b1; step();
      idle(); step(); step();
    end
    #1;
    chk("t9_sat", {30'd0, o_redirect_cnt}, 32'd3);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 99) == 0);
      i_stall        = ($urandom_range(0, 3) == 0);
      i_branch_flush = ($urandom_range(0, 9) < 3);
      i_branch_pc    = {$urandom() & 32'hFFFF_FFF0, ($urandom_range(0, 3) == 0) ? 2'(  $urandom_range(1, 3)) : 2'b00} ;
      i_trap         = ($urandom_range(0, 9) == 0);
      i_trap_pc      = $urandom() & 32'hFFFF_FFFC;
      i_imem_ack     = ($urandom_range(0, 9) < 4);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
